// File: rtl/mem_io_ctrl.sv
// Memory/IO access controller: address decode, variable-latency memory handshake,
// memory-mapped keyboard/display registers and the INMUX data/select outputs.
module mem_io_ctrl #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR_OUT,
  input  logic [15:0] MDR_OUT,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  output logic [1:0]  INMUX_SEL,
  output logic [15:0] KBDR_OUT,
  output logic [15:0] KBSR_OUT,
  output logic [15:0] DSR_OUT,
  output logic [15:0] MEM_OUT,
  output logic        R,
  input  logic        KB_VALID,
  input  logic [7:0]  KB_DATA,
  output logic        KB_READY,
  output logic        DISP_VALID,
  output logic [7:0]  DISP_DATA,
  input  logic        DISP_ACK
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LATENCY - 1);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  localparam logic [1:0] SEL_KBDR = 2'b00;
  localparam logic [1:0] SEL_KBSR = 2'b01;
  localparam logic [1:0] SEL_DSR  = 2'b10;
  localparam logic [1:0] SEL_MEM  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DEV      = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DEV_KBSR = 2'd0,
    DEV_KBDR = 2'd1,
    DEV_DSR  = 2'd2,
    DEV_DDR  = 2'd3
  } dev_t;

  state_t        state_q, state_d;
  dev_t          dev_q, dev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic [15:0]   mem_out_q, mem_out_d;
  logic [1:0]    inmux_sel_q, inmux_sel_d;
  logic          r_q, r_d;
  logic [7:0]    kbdr_q, kbdr_d;
  logic          kbsr_rdy_q, kbsr_rdy_d;
  logic          kbsr_ie_q, kbsr_ie_d;
  logic          dsr_rdy_q, dsr_rdy_d;
  logic          dsr_ie_q, dsr_ie_d;
  logic [7:0]    ddr_q, ddr_d;
  logic          disp_valid_q, disp_valid_d;

  logic          addr_is_dev;
  dev_t          addr_dev;

  always_comb begin
    addr_is_dev = 1'b1;
    addr_dev    = DEV_KBSR;
    unique case (MAR_OUT)
      ADDR_KBSR: addr_dev = DEV_KBSR;
      ADDR_KBDR: addr_dev = DEV_KBDR;
      ADDR_DSR:  addr_dev = DEV_DSR;
      ADDR_DDR:  addr_dev = DEV_DDR;
      default:   addr_is_dev = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dev_d        = dev_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_out_d    = mem_out_q;
    inmux_sel_d  = inmux_sel_q;
    r_d          = 1'b0;
    kbdr_d       = kbdr_q;
    kbsr_rdy_d   = kbsr_rdy_q;
    kbsr_ie_d    = kbsr_ie_q;
    dsr_rdy_d    = dsr_rdy_q;
    dsr_ie_d     = dsr_ie_q;
    ddr_d        = ddr_q;
    disp_valid_d = disp_valid_q;

    if (KB_VALID && !kbsr_rdy_q) begin
      kbdr_d     = KB_DATA;
      kbsr_rdy_d = 1'b1;
    end
    if (DISP_ACK && disp_valid_q) begin
      disp_valid_d = 1'b0;
      dsr_rdy_d    = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (MIO_EN) begin
          mem_addr_d  = MAR_OUT;
          mem_wdata_d = MDR_OUT;
          mem_we_d    = R_W;
          cnt_d       = '0;
          if (addr_is_dev) begin
            state_d = ST_DEV;
            dev_d   = addr_dev;
            unique case (addr_dev)
              DEV_KBDR: inmux_sel_d = SEL_KBDR;
              DEV_KBSR: inmux_sel_d = SEL_KBSR;
              DEV_DSR:  inmux_sel_d = SEL_DSR;
              default:  inmux_sel_d = SEL_MEM;
            endcase
          end else begin
            state_d     = ST_MEM_WAIT;
            mem_en_d    = 1'b1;
            inmux_sel_d = SEL_MEM;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          if (!mem_we_q) mem_out_d = MEM_RDATA;
          state_d = ST_DONE;
          r_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DEV: begin
        unique case (dev_q)
          DEV_KBSR: if (mem_we_q) kbsr_ie_d = mem_wdata_q[14];
          // Guarded so a same-cycle keyboard acceptance into an empty KBDR is kept.
          DEV_KBDR: if (!mem_we_q && kbsr_rdy_q) kbsr_rdy_d = 1'b0;
          DEV_DSR:  if (mem_we_q) dsr_ie_d = mem_wdata_q[14];
          default: begin
            if (mem_we_q) begin
              if (dsr_rdy_q) begin
                ddr_d        = mem_wdata_q[7:0];
                dsr_rdy_d    = 1'b0;
                disp_valid_d = 1'b1;
              end
            end else begin
              mem_out_d = 16'h0000;
            end
          end
        endcase
        state_d = ST_DONE;
        r_d     = 1'b1;
      end
      default: begin
        if (MIO_EN) begin
          r_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      dev_q        <= DEV_KBSR;
      cnt_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      mem_out_q    <= 16'h0000;
      inmux_sel_q  <= SEL_MEM;
      r_q          <= 1'b0;
      kbdr_q       <= 8'h00;
      kbsr_rdy_q   <= 1'b0;
      kbsr_ie_q    <= 1'b0;
      dsr_rdy_q    <= 1'b1;
      dsr_ie_q     <= 1'b0;
      ddr_q        <= 8'h00;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dev_q        <= dev_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_out_q    <= mem_out_d;
      inmux_sel_q  <= inmux_sel_d;
      r_q          <= r_d;
      kbdr_q       <= kbdr_d;
      kbsr_rdy_q   <= kbsr_rdy_d;
      kbsr_ie_q    <= kbsr_ie_d;
      dsr_rdy_q    <= dsr_rdy_d;
      dsr_ie_q     <= dsr_ie_d;
      ddr_q        <= ddr_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign MEM_EN     = mem_en_q;
  assign MEM_WE     = mem_we_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_WDATA  = mem_wdata_q;
  assign MEM_OUT    = mem_out_q;
  assign INMUX_SEL  = inmux_sel_q;
  assign R          = r_q;
  assign KBDR_OUT   = {8'h00, kbdr_q};
  assign KBSR_OUT   = {kbsr_rdy_q, kbsr_ie_q, 14'b0};
  assign DSR_OUT    = {dsr_rdy_q, dsr_ie_q, 14'b0};
  assign KB_READY   = ~kbsr_rdy_q;
  assign DISP_VALID = disp_valid_q;
  assign DISP_DATA  = ddr_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Randomized bench for mem_io_ctrl: directed scenarios then random accesses,
// keyboard offers and display acks, checked against a transaction-level model.
module tb_mem_io_ctrl;
  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MIO_EN = 1'b0;
  logic        R_W = 1'b0;
  logic [15:0] MAR_OUT = 16'h0;
  logic [15:0] MDR_OUT = 16'h0;
  logic        MEM_EN, MEM_WE;
  logic [15:0] MEM_ADDR, MEM_WDATA;
  logic [15:0] MEM_RDATA = 16'h0;
  logic [1:0]  INMUX_SEL;
  logic [15:0] KBDR_OUT, KBSR_OUT, DSR_OUT, MEM_OUT;
  logic        R;
  logic        KB_VALID = 1'b0;
  logic [7:0]  KB_DATA = 8'h0;
  logic        KB_READY, DISP_VALID;
  logic [7:0]  DISP_DATA;
  logic        DISP_ACK = 1'b0;

  mem_io_ctrl #(.MEM_LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .MIO_EN(MIO_EN), .R_W(R_W),
    .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .INMUX_SEL(INMUX_SEL),
    .KBDR_OUT(KBDR_OUT), .KBSR_OUT(KBSR_OUT), .DSR_OUT(DSR_OUT), .MEM_OUT(MEM_OUT),
    .R(R), .KB_VALID(KB_VALID), .KB_DATA(KB_DATA), .KB_READY(KB_READY),
    .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA), .DISP_ACK(DISP_ACK)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // External memory: data appears only in the cycle the controller samples it.
  logic [15:0] phys [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          mcnt = 0;
  logic [15:0] maddr = 16'h0;
  int          en_pulses = 0;

  always @(negedge CLK) begin
    if (MEM_EN) begin
      mcnt  = 1;
      maddr = MEM_ADDR;
      en_pulses++;
      if (MEM_WE) phys[MEM_ADDR] = MEM_WDATA;
    end else if (mcnt != 0) begin
      mcnt = (mcnt > LAT) ? 0 : mcnt + 1;
    end
    MEM_RDATA = (mcnt == LAT) ? phys[maddr] : 16'($urandom);
  end

  // Behavioural model of device registers
  bit          kb_full, kb_ie, d_ready, d_ie, pend;
  logic [7:0]  kb_key, ddr;
  logic [15:0] exp_mem_out;

  task automatic model_reset();
    kb_full = 0; kb_ie = 0; kb_key = 8'h0;
    d_ready = 1; d_ie = 0; ddr = 8'h0; pend = 0;
    exp_mem_out = 16'h0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_regs();
    check_val("kbsr", KBSR_OUT, {kb_full, kb_ie, 14'b0});
    check_val("kbdr", KBDR_OUT, {8'h00, kb_key});
    check_val("dsr", DSR_OUT, {d_ready, d_ie, 14'b0});
    check_val("mem_out", MEM_OUT, exp_mem_out);
    check_val("disp_valid", 16'(DISP_VALID), 16'(pend));
    check_val("disp_data", 16'(DISP_DATA), 16'(ddr));
    check_val("kb_ready", 16'(KB_READY), 16'(!kb_full));
  endtask

  task automatic kb_offer(input logic [7:0] d);
    KB_VALID = 1; KB_DATA = d;
    tick();
    KB_VALID = 0;
    if (!kb_full) begin kb_key = d; kb_full = 1; end
    check_regs();
  endtask

  task automatic disp_ack();
    DISP_ACK = 1;
    tick();
    DISP_ACK = 0;
    pend = 0; d_ready = 1;
    check_regs();
  endtask

  task automatic do_access(input bit we, input logic [15:0] addr, input logic [15:0] data,
                           input int hold, input bit early_drop);
    int cyc;
    int p0;
    bit dev;
    logic [1:0] sel;
    dev = addr inside {16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06};
    sel = (addr == 16'hFE02) ? 2'b00 : (addr == 16'hFE00) ? 2'b01 :
          (addr == 16'hFE04) ? 2'b10 : 2'b11;
    p0 = en_pulses;
    MIO_EN = 1; R_W = we; MAR_OUT = addr; MDR_OUT = data;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (early_drop && cyc == 1) MIO_EN = 0;
    end while (!R && cyc < 30);
    check_val("latency", 16'(cyc), dev ? 16'd2 : 16'(LAT + 1));
    check_val("inmux_sel", 16'(INMUX_SEL), 16'(sel));
    if (!early_drop) begin
      for (int h = 1; h < hold; h++) begin
        tick();
        check_val("r_hold", 16'(R), 16'd1);
      end
    end
    MIO_EN = 0;
    tick();
    check_val("r_drop", 16'(R), 16'd0);
    check_val("mem_en_count", 16'(en_pulses - p0), dev ? 16'd0 : 16'd1);
    if (!dev) begin
      if (we) ref_mem[addr] = data;
      else    exp_mem_out = ref_mem[addr];
    end else begin
      case (addr)
        16'hFE00: if (we) kb_ie = data[14];
        16'hFE02: if (!we) kb_full = 0;
        16'hFE04: if (we) d_ie = data[14];
        default: begin
          if (we) begin
            if (d_ready) begin ddr = data[7:0]; d_ready = 0; pend = 1; end
          end else begin
            exp_mem_out = 16'h0;
          end
        end
      endcase
    end
    check_regs();
  endtask

  logic [15:0] dev_addrs [4] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06};

  initial begin
    for (int i = 0; i < 64; i++) begin
      phys[16'h3000 + i]    = 16'($urandom);
      ref_mem[16'h3000 + i] = phys[16'h3000 + i];
    end
    phys[16'h3000] = 16'h1234;
    ref_mem[16'h3000] = 16'h1234;
    model_reset();

    repeat (3) tick();
    check_regs();
    check_val("rst_r", 16'(R), 16'd0);
    check_val("rst_mem_en", 16'(MEM_EN), 16'd0);
    check_val("rst_sel", 16'(INMUX_SEL), 16'd3);
    check_val("rst_addr", MEM_ADDR, 16'h0);
    check_val("rst_wdata", MEM_WDATA, 16'h0);
    RST = 0;
    tick();

    do_access(0, 16'h3000, 16'h0, 1, 0);
    check_val("mem_read_x1234", MEM_OUT, 16'h1234);

    kb_offer(8'h41);
    check_val("kbsr_full", KBSR_OUT, 16'h8000);
    kb_offer(8'h55);
    do_access(0, 16'hFE02, 16'h0, 1, 0);
    check_val("kbdr_x41", KBDR_OUT, 16'h0041);

    do_access(1, 16'hFE06, 16'h0058, 1, 0);
    check_val("disp_x58", 16'(DISP_DATA), 16'h0058);
    do_access(1, 16'hFE06, 16'h0077, 1, 0);
    disp_ack();
    check_val("dsr_after_ack", DSR_OUT, 16'h8000);

    do_access(1, 16'hFE00, 16'hFFFF, 1, 0);
    check_val("kbsr_ie_only", KBSR_OUT, 16'h4000);

    do_access(0, 16'h3001, 16'h0, 3, 0);
    do_access(1, 16'h3002, 16'hBEEF, 2, 1);
    do_access(0, 16'h3002, 16'h0, 1, 1);
    do_access(1, 16'hFE04, 16'h4000, 1, 1);
    do_access(0, 16'hFE06, 16'h0, 1, 0);

    // Reset in the middle of a memory read
    do_access(0, 16'h3003, 16'h0, 1, 0);
    do_access(1, 16'hFE06, 16'h0011, 1, 0);
    MIO_EN = 1; R_W = 0; MAR_OUT = 16'h3004;
    tick();
    tick();
    RST = 1;
    #1;
    check_val("midrst_r", 16'(R), 16'd0);
    check_val("midrst_mem_en", 16'(MEM_EN), 16'd0);
    check_val("midrst_sel", 16'(INMUX_SEL), 16'd3);
    check_val("midrst_dsr", DSR_OUT, 16'h8000);
    MIO_EN = 0;
    tick();
    RST = 0;
    model_reset();
    repeat (LAT + 3) tick();
    check_regs();
    check_val("late_rdata_dropped", MEM_OUT, 16'h0);

    for (int it = 0; it < 250; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 1) begin
        kb_offer(8'($urandom));
      end else if (act == 2) begin
        if (pend) disp_ack();
      end else begin
        logic [15:0] a;
        int asel;
        asel = $urandom_range(0, 9);
        if (asel < 5)      a = dev_addrs[$urandom_range(0, 3)];
        else if (asel < 9) a = 16'h3000 + 16'($urandom_range(0, 63));
        else               a = 16'($urandom);
        do_access(1'($urandom), a, 16'($urandom), $urandom_range(1, 3),
                  ($urandom_range(0, 7) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
